// File: rtl/tt_vec_idp_seq_if.sv
// Request / issue / writeback bundle of the vector-integer beat sequencer.
// Master drives op descriptors, writeback readiness and flush; slave is the sequencer.
// Ports: request handshake + descriptor, i_wb_rdy, i_kill, per-beat issue strobes and flags, busy/done.
interface tt_vec_idp_seq_if;
  logic       i_req_vld;
  logic       o_req_rdy;
  logic [2:0] i_req_lmul;
  logic       i_req_wdeop;
  logic       i_req_nrwop;
  logic       i_req_mulen;
  logic       i_wb_rdy;
  logic       i_kill;
  logic       o_vex_en_0a;
  logic       o_vex_en_1a;
  logic [2:0] o_lmul_cnt_0a;
  logic       o_first_0a;
  logic       o_last_0a;
  logic       o_busy;
  logic       o_done;

  modport master (
    output i_req_vld, i_req_lmul, i_req_wdeop, i_req_nrwop, i_req_mulen, i_wb_rdy, i_kill,
    input  o_req_rdy, o_vex_en_0a, o_vex_en_1a, o_lmul_cnt_0a, o_first_0a, o_last_0a,
           o_busy, o_done
  );

  modport slave (
    input  i_req_vld, i_req_lmul, i_req_wdeop, i_req_nrwop, i_req_mulen, i_wb_rdy, i_kill,
    output o_req_rdy, o_vex_en_0a, o_vex_en_1a, o_lmul_cnt_0a, o_first_0a, o_last_0a,
           o_busy, o_done
  );
endinterface

// File: rtl/tt_vec_idp_seq.sv
// Purpose: splits one vector-integer op descriptor into per-register beats (1<<leff) for the add/mul datapath.
// Latency: first beat issues the cycle after accept; o_done 1 (add) or 2 (mul) cycles after the last beat.
// Backpressure: i_wb_rdy=0 stalls issue with the beat counter held; descriptors accepted only while idle.
// Ports: i_clk, i_reset (async, active-high), bus (slave modport): request handshake/descriptor,
//        i_wb_rdy, i_kill, o_vex_en_0a/1a, o_lmul_cnt_0a, o_first_0a, o_last_0a, o_busy, o_done.
module tt_vec_idp_seq #(
  parameter int unsigned VLEN      = 256,
  parameter int unsigned MAX_BEATS = 8
) (
  input logic              i_clk,
  input logic              i_reset,
  tt_vec_idp_seq_if.slave  bus
);

  localparam logic [2:0] LEFF_MAX = 3'((MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 0);
  // An illegal configuration never accepts work rather than issuing malformed beats.
  localparam bit CFG_OK = (VLEN >= 64) && ((VLEN & (VLEN - 1)) == 0) &&
                          (MAX_BEATS <= 8) && ((MAX_BEATS & (MAX_BEATS - 1)) == 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] cnt_q;
  logic [2:0] last_idx_q;
  logic       mul_q;
  logic [1:0] lat_q;
  logic       en_1a_q;

  logic       req_rdy;
  logic       vex_en_0a;
  logic       done;
  logic       accept;
  logic       last_issue;
  logic [2:0] lmul_base;
  logic [2:0] leff_raw;
  logic [2:0] leff;
  logic [2:0] last_idx_d;

  // Fractional LMUL still occupies one whole register; widening/narrowing doubles the register count.
  assign lmul_base  = bus.i_req_lmul[2] ? 3'd0 : {1'b0, bus.i_req_lmul[1:0]};
  assign leff_raw   = lmul_base + {2'b00, bus.i_req_wdeop | bus.i_req_nrwop};
  assign leff       = (leff_raw > LEFF_MAX) ? LEFF_MAX : leff_raw;
  // Index of the final beat, (1<<leff)-1, formed without a 4-bit intermediate.
  assign last_idx_d = ~(3'b111 << leff);

  assign accept     = bus.i_req_vld & req_rdy;
  assign last_issue = vex_en_0a & (cnt_q == last_idx_q);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    req_rdy   = 1'b0;
    vex_en_0a = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // Depends on i_kill only, never on i_req_vld.
        req_rdy = CFG_OK & ~bus.i_kill;
        if (bus.i_req_vld && req_rdy) begin
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        vex_en_0a = bus.i_wb_rdy & ~bus.i_kill;
        if (bus.i_kill) begin
          state_d = ST_IDLE;
        end else if (vex_en_0a && (cnt_q == last_idx_q)) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (bus.i_kill) begin
          state_d = ST_IDLE;
        end else if (lat_q == 2'd1) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cnt_q      <= 3'd0;
      last_idx_q <= 3'd0;
      mul_q      <= 1'b0;
      lat_q      <= 2'd0;
      en_1a_q    <= 1'b0;
    end else begin
      // vex_en_0a is already low during a kill, so the 1a copy clears with it.
      en_1a_q <= vex_en_0a;
      if (accept) begin
        cnt_q      <= 3'd0;
        last_idx_q <= last_idx_d;
        mul_q      <= bus.i_req_mulen;
      end else if (bus.i_kill) begin
        cnt_q <= 3'd0;
        lat_q <= 2'd0;
      end else if (last_issue) begin
        // Counter parks at zero instead of wrapping; lat_q counts down to the result-valid cycle.
        cnt_q <= 3'd0;
        lat_q <= mul_q ? 2'd2 : 2'd1;
      end else if (vex_en_0a) begin
        cnt_q <= cnt_q + 3'd1;
      end else if (state_q == ST_DRAIN) begin
        lat_q <= lat_q - 2'd1;
      end
    end
  end

  assign bus.o_req_rdy     = req_rdy;
  assign bus.o_vex_en_0a   = vex_en_0a;
  assign bus.o_vex_en_1a   = en_1a_q;
  assign bus.o_lmul_cnt_0a = cnt_q;
  assign bus.o_first_0a    = vex_en_0a & (cnt_q == 3'd0);
  assign bus.o_last_0a     = last_issue;
  assign bus.o_busy        = (state_q != ST_IDLE);
  assign bus.o_done        = done;

endmodule

// File: tb/tb_tt_vec_idp_seq.sv
// Directed bench for tt_vec_idp_seq: each window drives a per-cycle stimulus table and compares every
// cycle against a timeline derived from the op rules; literal checks pin key cycles of each case.
module tb_tt_vec_idp_seq;
  localparam int W = 24;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tt_vec_idp_seq_if bus();

  tt_vec_idp_seq #(.VLEN(256), .MAX_BEATS(8)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  // Stimulus table (one entry per window cycle)
  bit       s_vld [W];
  bit [2:0] s_lmul[W];
  bit       s_w   [W];
  bit       s_n   [W];
  bit       s_mul [W];
  bit       s_wb  [W];
  bit       s_kill[W];

  // Expected timeline
  bit       e_en  [W];
  bit [2:0] e_cnt [W];
  bit       e_fst [W];
  bit       e_lst [W];
  bit       e_done[W];
  bit       e_busy[W];
  bit       e_rdy [W];
  bit       e_en1a[W];

  // Observations for literal checks
  bit o_rdy [W];
  bit o_en1a[W];
  int obs_done_cyc, obs_n_done, obs_n_issue, obs_last_issue, obs_max_cnt;
  int obs_acc[$];

  int n_cmp = 0;
  int n_bad = 0;
  int wc = 0;
  bit active = 1'b0;

  task automatic chk(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic clear_stim();
    for (int c = 0; c < W; c++) begin
      s_vld[c] = 0; s_lmul[c] = 0; s_w[c] = 0; s_n[c] = 0; s_mul[c] = 0;
      s_wb[c] = 1; s_kill[c] = 0;
    end
  endtask

  task automatic set_req(input int from, input int to, input int lmul, input bit w, input bit n,
                         input bit mul);
    for (int c = from; c <= to; c++) begin
      s_vld[c] = 1; s_lmul[c] = 3'(lmul); s_w[c] = w; s_n[c] = n; s_mul[c] = mul;
    end
  endtask

  // Timeline model: an accepted op issues its beats on the following cycles where writeback is
  // ready, its result appears lat cycles after the last beat, and the unit is idle the cycle after.
  // A kill ends the op in that cycle with no completion.
  task automatic build_exp(input int len);
    int idle_from, leff, beats, lat, i, t;
    bit killed;
    for (int c = 0; c < W; c++) begin
      e_en[c] = 0; e_cnt[c] = 0; e_fst[c] = 0; e_lst[c] = 0;
      e_done[c] = 0; e_busy[c] = 0; e_rdy[c] = 0; e_en1a[c] = 0;
    end
    idle_from = 0;
    for (int c = 0; c < len; c++) begin
      if (c < idle_from) continue;
      e_rdy[c] = !s_kill[c];
      if (s_vld[c] && !s_kill[c]) begin
        leff  = (s_lmul[c] > 3 ? 0 : int'(s_lmul[c])) + ((s_w[c] || s_n[c]) ? 1 : 0);
        if (leff > 3) leff = 3;
        beats = 1 << leff;
        lat   = s_mul[c] ? 2 : 1;
        i = 0; t = c + 1; killed = 0;
        while (i < beats && t < len) begin
          e_busy[t] = 1;
          if (s_kill[t]) begin killed = 1; break; end
          if (s_wb[t]) begin
            e_en[t] = 1; e_cnt[t] = 3'(i); e_fst[t] = (i == 0); e_lst[t] = (i == beats - 1);
            i++;
          end
          t++;
        end
        if (!killed) begin
          for (int d = 0; d < lat && t < len; d++) begin
            e_busy[t] = 1;
            if (s_kill[t]) begin killed = 1; break; end
            if (d == lat - 1) e_done[t] = 1;
            t++;
          end
        end
        idle_from = t + (killed ? 1 : 0);
      end
    end
    for (int c = 1; c < len; c++) e_en1a[c] = e_en[c-1];
  endtask

  // Single per-cycle compare process against the model timeline
  always @(negedge clk) begin
    if (active) begin
      chk("vex_en_0a", wc, 32'(bus.o_vex_en_0a), 32'(e_en[wc]));
      chk("vex_en_1a", wc, 32'(bus.o_vex_en_1a), 32'(e_en1a[wc]));
      chk("first_0a",  wc, 32'(bus.o_first_0a),  32'(e_fst[wc]));
      chk("last_0a",   wc, 32'(bus.o_last_0a),   32'(e_lst[wc]));
      chk("done",      wc, 32'(bus.o_done),      32'(e_done[wc]));
      chk("busy",      wc, 32'(bus.o_busy),      32'(e_busy[wc]));
      chk("req_rdy",   wc, 32'(bus.o_req_rdy),   32'(e_rdy[wc]));
      if (e_en[wc]) chk("lmul_cnt", wc, 32'(bus.o_lmul_cnt_0a), 32'(e_cnt[wc]));
      o_rdy[wc]  = bus.o_req_rdy;
      o_en1a[wc] = bus.o_vex_en_1a;
      if (bus.o_done === 1'b1) begin obs_done_cyc = wc; obs_n_done++; end
      if (bus.o_vex_en_0a === 1'b1) begin
        obs_n_issue++; obs_last_issue = wc;
        if (int'(bus.o_lmul_cnt_0a) > obs_max_cnt) obs_max_cnt = int'(bus.o_lmul_cnt_0a);
      end
      if (bus.i_req_vld && bus.o_req_rdy === 1'b1) obs_acc.push_back(wc);
    end
  end

  task automatic drive_idle();
    bus.i_req_vld = 0; bus.i_req_lmul = 0; bus.i_req_wdeop = 0; bus.i_req_nrwop = 0;
    bus.i_req_mulen = 0; bus.i_wb_rdy = 1; bus.i_kill = 0;
  endtask

  task automatic run_window(input int len);
    build_exp(len);
    obs_done_cyc = -1; obs_n_done = 0; obs_n_issue = 0; obs_last_issue = -1; obs_max_cnt = -1;
    obs_acc.delete();
    for (int c = 0; c < W; c++) begin o_rdy[c] = 0; o_en1a[c] = 0; end
    for (int c = 0; c < len; c++) begin
      @(posedge clk); #1;
      bus.i_req_vld   = s_vld[c];
      bus.i_req_lmul  = s_lmul[c];
      bus.i_req_wdeop = s_w[c];
      bus.i_req_nrwop = s_n[c];
      bus.i_req_mulen = s_mul[c];
      bus.i_wb_rdy    = s_wb[c];
      bus.i_kill      = s_kill[c];
      wc = c;
      active = 1;
    end
    @(posedge clk); #1;
    active = 0;
    drive_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "bench timeout");
  end

  initial begin
    drive_idle();
    clear_stim();
    #3;
    chk("rst_rdy",  -1, 32'(bus.o_req_rdy),    32'd1);
    chk("rst_busy", -1, 32'(bus.o_busy),       32'd0);
    chk("rst_en0a", -1, 32'(bus.o_vex_en_0a),  32'd0);
    chk("rst_done", -1, 32'(bus.o_done),       32'd0);
    chk("rst_cnt",  -1, 32'(bus.o_lmul_cnt_0a), 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // lmul=2 add, wb always ready
    clear_stim(); set_req(0, 0, 2, 0, 0, 0);
    run_window(10);
    chk("s1_issues", -1, obs_n_issue, 4);
    chk("s1_last",   -1, obs_last_issue, 4);
    chk("s1_done",   -1, obs_done_cyc, 5);
    chk("s1_rdy5",   -1, 32'(o_rdy[5]), 32'd0);
    chk("s1_rdy6",   -1, 32'(o_rdy[6]), 32'd1);

    // lmul=1 widening multiply
    clear_stim(); set_req(0, 0, 1, 1, 0, 1);
    run_window(10);
    chk("s2_issues", -1, obs_n_issue, 4);
    chk("s2_en1a5",  -1, 32'(o_en1a[5]), 32'd1);
    chk("s2_en1a6",  -1, 32'(o_en1a[6]), 32'd0);
    chk("s2_done",   -1, obs_done_cyc, 6);

    // lmul=3 narrowing saturates at 8 beats
    clear_stim(); set_req(0, 0, 3, 0, 1, 0);
    run_window(13);
    chk("s3_issues", -1, obs_n_issue, 8);
    chk("s3_maxcnt", -1, obs_max_cnt, 7);
    chk("s3_done",   -1, obs_done_cyc, 9);

    // lmul=2 add with writeback stall at 2,3
    clear_stim(); set_req(0, 0, 2, 0, 0, 0); s_wb[2] = 0; s_wb[3] = 0;
    run_window(11);
    chk("s4_last", -1, obs_last_issue, 6);
    chk("s4_done", -1, obs_done_cyc, 7);

    // lmul=3 mul killed on beat 3; kill also blocks a request in idle; next op completes
    clear_stim(); set_req(0, 0, 3, 0, 0, 1); s_kill[4] = 1; s_kill[5] = 1;
    set_req(5, 6, 0, 0, 0, 0);
    run_window(12);
    chk("s5_issues", -1, obs_n_issue, 4);
    chk("s5_ndone",  -1, obs_n_done, 1);
    chk("s5_done",   -1, obs_done_cyc, 8);
    chk("s5_acc2",   -1, (obs_acc.size() > 1) ? obs_acc[1] : -1, 6);

    // back-to-back spacing: add beats+2, mul beats+3
    clear_stim(); set_req(0, 7, 2, 0, 0, 0);
    run_window(14);
    chk("s6_acc2_add", -1, (obs_acc.size() > 1) ? obs_acc[1] : -1, 6);
    clear_stim(); set_req(0, 7, 2, 0, 0, 1);
    run_window(16);
    chk("s6_acc2_mul", -1, (obs_acc.size() > 1) ? obs_acc[1] : -1, 7);

    // async reset in the middle of an 8-beat op
    clear_stim(); set_req(0, 0, 3, 0, 0, 0);
    run_window(4);
    chk("s7_pre_en", -1, 32'(bus.o_vex_en_0a), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("s7_en0a", -1, 32'(bus.o_vex_en_0a),   32'd0);
    chk("s7_en1a", -1, 32'(bus.o_vex_en_1a),   32'd0);
    chk("s7_busy", -1, 32'(bus.o_busy),        32'd0);
    chk("s7_cnt",  -1, 32'(bus.o_lmul_cnt_0a), 32'd0);
    chk("s7_fst",  -1, 32'(bus.o_first_0a),    32'd0);
    @(negedge clk);
    rst = 1'b0;
    clear_stim();
    run_window(4);
    chk("s7_ndone", -1, obs_n_done, 0);
    chk("s7_rdy",   -1, 32'(o_rdy[0]), 32'd1);

    // fractional lmul -> single beat
    clear_stim(); set_req(0, 0, 5, 0, 0, 0);
    run_window(5);
    chk("s8_issues", -1, obs_n_issue, 1);
    chk("s8_done",   -1, obs_done_cyc, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
